// File: rtl/ecg_win_rx_pkg.sv
// ---------------------------------------------------------------------------
// ecg_win_rx_pkg
//   Shared definitions for the ECG sliding-window receiver:
//   - default sample width / kernel / stride / FIFO depth / counter width
//   - FSM state encoding
//   - bit offsets of the flag fields inside a FIFO entry
//
//   FIFO entry layout (width DW+2):
//     [DW+ENT_DATA_OFS] is_data : 1 = sample entry, 0 = end-of-record marker
//     [DW+ENT_EOR_OFS]  eor     : record ends with (or at) this entry
//     [DW-1:0]          sample
// ---------------------------------------------------------------------------
package ecg_win_rx_pkg;

  localparam int DEF_DW         = 7;
  localparam int DEF_KERNEL     = 5;
  localparam int DEF_STRIDE     = 2;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_CW         = 16;

  // Flag offsets measured from the top of the sample field.
  localparam int ENT_EOR_OFS  = 0;
  localparam int ENT_DATA_OFS = 1;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,  // popping samples into the window register
    S_EMIT = 2'd1,  // window presented, waiting for win_rdy
    S_DONE = 2'd2   // one-cycle end-of-record report
  } state_t;

  // Width of one FIFO entry for a given sample width.
  function automatic int entry_width(input int dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/ecg_win_rx_fifo.sv
// ---------------------------------------------------------------------------
// ecg_win_rx_fifo
//   Synchronous show-ahead FIFO. rd_data always shows the oldest entry while
//   empty=0. A push while full is accepted only if a pop happens in the same
//   cycle; otherwise it is ignored (the caller flags the overflow). A pop
//   while empty is ignored.
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//     push         write wr_data this cycle
//     wr_data      entry to write
//     pop          remove the entry shown on rd_data
//     rd_data      oldest entry
//     full, empty  occupancy flags
// ---------------------------------------------------------------------------
module ecg_win_rx_fifo
  import ecg_win_rx_pkg::*;
#(
  parameter int W     = entry_width(DEF_DW),
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // One extra wrap bit on each pointer distinguishes full from empty.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one being popped this cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define which
  // entries are valid, and a reset here would block RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ecg_win_rx.sv
// ---------------------------------------------------------------------------
// ecg_win_rx
//   Receive end of the sliding-window sample stream. Samples (and
//   end-of-record markers) are buffered in a small FIFO because the producer
//   has no backpressure; an FSM pops them into a KERNEL-deep window register
//   and presents a window every STRIDE new samples on a valid/ready
//   handshake. Each record ends with a one-cycle frame_done carrying the
//   number of windows emitted.
//
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     slide_data    incoming sample, qualified by ecg_data_val
//     ecg_data_val  sample valid (at most one per cycle)
//     trans_done    end-of-record pulse (with the last sample or alone later)
//     win_data      window; [DW-1:0] oldest sample, top slice newest
//     win_val       window valid
//     win_rdy       downstream ready
//     frame_done    one-cycle pulse after the last window of a record
//     frame_len     windows in the finished record; held until next frame_done
//     overflow      sticky: a push was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module ecg_win_rx
  import ecg_win_rx_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int KERNEL     = DEF_KERNEL,
  parameter int STRIDE     = DEF_STRIDE,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CW         = DEF_CW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DW-1:0]        slide_data,
  input  logic                 ecg_data_val,
  input  logic                 trans_done,
  output logic [KERNEL*DW-1:0] win_data,
  output logic                 win_val,
  input  logic                 win_rdy,
  output logic                 frame_done,
  output logic [CW-1:0]        frame_len,
  output logic                 overflow
);

  localparam int EW = entry_width(DW);
  localparam int FW = $clog2(KERNEL + 1);
  localparam int SW = $clog2(STRIDE + 1);

  localparam logic [FW-1:0] FILL_FULL  = FW'(KERNEL);
  localparam logic [SW-1:0] STRIDE_VAL = SW'(STRIDE);

  // -------------------------------------------------------------------------
  // Input side: every sample or lone end-of-record pulse becomes one entry.
  // -------------------------------------------------------------------------
  logic          push_req;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  assign push_req   = ecg_data_val || trans_done;
  assign push_entry = ecg_data_val ? {1'b1, trans_done, slide_data}
                                   : {1'b0, 1'b1, {DW{1'b0}}};

  ecg_win_rx_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_req),
    .wr_data (push_entry),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A full FIFO still takes the push when the head leaves in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Head-of-FIFO decode and window bookkeeping.
  // -------------------------------------------------------------------------
  logic          head_is_data;
  logic          head_eor;
  logic [DW-1:0] head_sample;

  assign head_is_data = head[DW+ENT_DATA_OFS];
  assign head_eor     = head[DW+ENT_EOR_OFS];
  assign head_sample  = head[DW-1:0];

  state_t                state_q;
  state_t                state_d;
  logic [KERNEL*DW-1:0]  win_reg;
  logic [FW-1:0]         fill;
  logic [SW-1:0]         stride_cnt;
  logic [CW-1:0]         win_cnt;
  logic [CW-1:0]         frame_len_q;
  logic                  eor_pend;

  logic [FW-1:0]         fill_nxt;
  logic [SW-1:0]         stride_nxt;
  logic                  emit_hit;

  // Values the counters take if the head sample is shifted in this cycle.
  assign fill_nxt   = (fill == FILL_FULL) ? fill : fill + 1'b1;
  assign stride_nxt = (stride_cnt == '0) ? '0 : stride_cnt - 1'b1;
  assign emit_hit   = (fill_nxt == FILL_FULL) && (stride_nxt == '0);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FILL: begin
        if (!fifo_empty) begin
          if (!head_is_data) begin
            state_d = S_DONE;
          end else if (emit_hit) begin
            state_d = S_EMIT;       // eor, if any, is handled after the window
          end else if (head_eor) begin
            state_d = S_DONE;
          end
        end
      end
      S_EMIT: begin
        if (win_rdy) state_d = eor_pend ? S_DONE : S_FILL;
      end
      S_DONE:  state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    pop        = (state_q == S_FILL) && !fifo_empty;
    win_val    = (state_q == S_EMIT);
    frame_done = (state_q == S_DONE);
    // frame_len shows the live count during S_DONE and the captured copy after.
    frame_len  = frame_done ? win_cnt : frame_len_q;
  end

  assign win_data = win_reg;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_reg     <= '0;
      fill        <= '0;
      stride_cnt  <= '0;
      win_cnt     <= '0;
      frame_len_q <= '0;
      eor_pend    <= 1'b0;
    end else begin
      unique case (state_q)
        S_FILL: begin
          if (pop && head_is_data) begin
            // Newest sample enters at the top; the oldest falls off the bottom.
            win_reg    <= {head_sample, win_reg[KERNEL*DW-1:DW]};
            fill       <= fill_nxt;
            stride_cnt <= stride_nxt;
            if (emit_hit) eor_pend <= head_eor;
          end
        end
        S_EMIT: begin
          if (win_rdy) begin
            if (win_cnt != '1) win_cnt <= win_cnt + 1'b1;
            stride_cnt <= STRIDE_VAL;
          end
        end
        S_DONE: begin
          // Partial windows are discarded simply by restarting the fill count.
          frame_len_q <= win_cnt;
          fill        <= '0;
          stride_cnt  <= '0;
          win_cnt     <= '0;
          eor_pend    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
